// File: rtl/key_sched_iter_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES key-schedule iterator.
package key_sched_iter_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, GEN, DRAIN} ks_state_t;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RED_POLY  = 8'h1b;

   // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
   endfunction

   // Shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/rotword.sv
// RotWord: cyclic left rotation of a word by one byte.
module rotword (
   input  logic [31:0] w,
   output logic [31:0] r
);

   assign r = {w[23:0], w[31:24]};

endmodule

// File: rtl/sbox.sv
// AES forward S-box: GF(2^8) inverse followed by the affine transform.
module sbox
   import key_sched_iter_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] s
);

   logic [7:0] sq;
   logic [7:0] inv;

   // Inverse as a^254 = product of a^(2^k) for k=1..7; zero maps to zero.
   always_comb begin
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
   end

   assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/sub_word.sv
// SubWord: one S-box per byte lane, purely combinational.
module sub_word (
   input  logic [31:0] w,
   output logic [31:0] s
);

   for (genvar b = 0; b < 4; b++) begin : g_byte
      sbox u_sbox (.a(w[8*b +: 8]), .s(s[8*b +: 8]));
   end

endmodule

// File: rtl/key_sched_iter.sv
// Iterative AES key expansion: one schedule word per cycle from an NK-word
// sliding window, emitting one 128-bit round key per four words with
// valid/ready backpressure.
module key_sched_iter
   import key_sched_iter_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [32*NK-1:0]  key_in,
   output logic              busy,
   output logic [127:0]      rk_out,
   output logic [3:0]        rk_idx,
   output logic              rk_valid,
   input  logic              rk_ready,
   output logic              done
);

   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);

   if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("key_sched_iter: NK must be 4, 6 or 8");
   end

   ks_state_t           state;
   logic [32*NK-1:0]    key_q;
   logic [NK-1:0][31:0] win;     // win[0] = w[i-NK] ... win[NK-1] = w[i-1]
   logic [5:0]          wcnt;    // index of the next word to produce
   logic [2:0]          mcnt;    // wcnt mod NK, kept incrementally
   logic [7:0]          rcon;

   logic [31:0] prev_w, rot_w, sw_in, sw_out, temp, new_w;
   logic        xfer, key_done, stall, produce;

   rotword  u_rot (.w(prev_w), .r(rot_w));
   sub_word u_sub (.w(sw_in),  .s(sw_out));

   assign prev_w   = win[NK-1];
   assign xfer     = rk_valid & rk_ready;
   assign key_done = (wcnt[1:0] == 2'd3);
   // A word that would complete a round key waits until the held key leaves.
   assign stall    = key_done & rk_valid & ~rk_ready;
   assign produce  = ((state == LOAD) || (state == GEN)) & ~stall;
   assign done     = xfer & (rk_idx == 4'(NR));

   // Next schedule word; the single SubWord is shared by the RotWord and AES-256 paths.
   always_comb begin
      sw_in = (mcnt == 3'd0) ? rot_w : prev_w;
      temp  = prev_w;
      if (mcnt == 3'd0)
         temp = sw_out ^ {rcon, 24'h0};
      else if (NK == 8 && mcnt == 3'd4)
         temp = sw_out;
      new_w = (state == LOAD) ? key_q[32*NK-1 -: 32] : (win[0] ^ temp);
   end

   // Control FSM, window shift and round-key output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         rk_out   <= '0;
         rk_idx   <= '0;
         rcon     <= RCON_INIT;
         win      <= '0;
         key_q    <= '0;
         wcnt     <= '0;
         mcnt     <= '0;
      end else begin
         if (xfer) rk_valid <= 1'b0;
         if (produce) begin
            win  <= {new_w, win[NK-1:1]};
            mcnt <= (mcnt == 3'(NK-1)) ? 3'd0 : mcnt + 3'd1;
            if (wcnt != 6'(NW-1)) wcnt <= wcnt + 6'd1;
            // The last three words of the window are the first three of this key.
            if (key_done) begin
               rk_out   <= {win[NK-3], win[NK-2], win[NK-1], new_w};
               rk_idx   <= wcnt[5:2];
               rk_valid <= 1'b1;
            end
         end
         case (state)
            IDLE: if (start && !busy) begin
               key_q <= key_in;
               wcnt  <= '0;
               mcnt  <= '0;
               rcon  <= RCON_INIT;
               busy  <= 1'b1;
               state <= LOAD;
            end
            LOAD: if (produce) begin
               key_q <= key_q << 32;
               if (wcnt == 6'(NK-1)) state <= GEN;
            end
            GEN: if (produce) begin
               if (mcnt == 3'd0) rcon <= xtime(rcon);
               if (wcnt == 6'(NW-1)) state <= DRAIN;
            end
            DRAIN: if (done) begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_sched_iter.sv
// Bench for key_sched_iter: NK=4/6/8 instances checked against an array-based
// key-expansion model, with random keys and random backpressure.
module tb_key_sched_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   start, rdy, busy, vld, done;
   logic [127:0] key4;
   logic [191:0] key6;
   logic [255:0] key8;
   logic [127:0] rko [3];
   logic [3:0]   idx [3];

   int checks = 0, failures = 0;
   int cyc = 0, t0 = 0;
   bit mon_en = 1'b0;

   logic [7:0]   sbt [256];
   logic [127:0] exp_rk [3][16];
   logic [127:0] got [3][16];
   int           nx [3], ndone [3], done_edge [3];
   int           fv [3][16];
   logic         hold [3];
   logic [127:0] held [3];

   key_sched_iter #(.NK(4)) u_ks4 (.clk(clk), .rst(rst), .start(start[0]), .key_in(key4),
      .busy(busy[0]), .rk_out(rko[0]), .rk_idx(idx[0]), .rk_valid(vld[0]), .rk_ready(rdy[0]), .done(done[0]));
   key_sched_iter #(.NK(6)) u_ks6 (.clk(clk), .rst(rst), .start(start[1]), .key_in(key6),
      .busy(busy[1]), .rk_out(rko[1]), .rk_idx(idx[1]), .rk_valid(vld[1]), .rk_ready(rdy[1]), .done(done[1]));
   key_sched_iter #(.NK(8)) u_ks8 (.clk(clk), .rst(rst), .start(start[2]), .key_in(key8),
      .busy(busy[2]), .rk_out(rko[2]), .rk_idx(idx[2]), .rk_valid(vld[2]), .rk_ready(rdy[2]), .done(done[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
      checks++;
      if (obs !== req) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, req);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] v);
      return (v << 1) ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
   endfunction

   // S-box from log/antilog tables (generator 03) plus the bitwise affine map.
   task automatic build_sbox();
      logic [7:0] ex [256];
      logic [7:0] lg [256];
      logic [7:0] e, b, s, c;
      int li;
      c = 8'h63;
      e = 8'h01;
      for (int k = 0; k < 255; k++) begin
         ex[k] = e;
         lg[e] = 8'(k);
         e = e ^ xt(e);
      end
      for (int a = 0; a < 256; a++) begin
         li = int'(lg[a]);
         b  = (a == 0) ? 8'h00 : ex[(255 - li) % 255];
         for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
         sbt[a] = s;
      end
   endtask

   // Full-schedule expansion into an array, then grouped into round keys.
   task automatic model(input int m, input int nk, input logic [255:0] k);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nw;
      nw = 4 * (nk + 7);
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int j = 0; j < 16; j++)
         exp_rk[m][j] = (j <= nk + 6) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
   endtask

   // Output monitor: every visible key must be the next expected one.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int m = 0; m < 3; m++) begin
            if (hold[m]) chk("rk_stable", rko[m], held[m]);
            if (vld[m]) begin
               chk("rk_idx", 128'(idx[m]), 128'(nx[m]));
               chk("rk_out", rko[m], (nx[m] < 16) ? exp_rk[m][nx[m]] : '0);
               if (fv[m][idx[m]] < 0) fv[m][idx[m]] = cyc - t0;
               if (rdy[m]) begin
                  if (nx[m] < 16) got[m][nx[m]] = rko[m];
                  nx[m]++;
               end
            end
            if (done[m]) begin
               ndone[m]++;
               done_edge[m] = cyc - t0;
            end
            hold[m] = vld[m] & ~rdy[m];
            held[m] = rko[m];
         end
      end
   end

   // Start the selected instances and run them to completion.
   task automatic run(input logic [2:0] which, input bit rnd, input bit poke);
      int k;
      for (int m = 0; m < 3; m++) begin
         nx[m] = 0; ndone[m] = 0; done_edge[m] = -1; hold[m] = 1'b0;
         for (int j = 0; j < 16; j++) begin
            fv[m][j] = -1;
            got[m][j] = '0;
         end
      end
      rdy = 3'b111;
      @(posedge clk); #1 start = which;
      @(posedge clk); #1 t0 = cyc; start = '0; mon_en = 1'b1;
      k = 0;
      while ((busy & which) != 3'b000 && k < 600) begin
         rdy = rnd ? 3'($urandom_range(0, 7)) : 3'b111;
         start[0] = poke && (k == 4 || k == 29 || k == 44);
         @(posedge clk); #1 k = cyc - t0;
      end
      start = '0;
      chk("run_timeout", 128'(busy & which), 128'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = '0; rdy = '0; key4 = '0; key6 = '0; key8 = '0;
      build_sbox();
      repeat (3) @(negedge clk);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_valid", 128'(vld), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_rk_out", rko[0], '0);
      chk("rst_rk_idx", 128'(idx[0]), 128'(0));
      rst = 1'b0;

      // FIPS-197 AES-128 vector, no backpressure: latency and done timing
      key4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      model(0, 4, {key4, 128'h0});
      run(3'b001, 1'b0, 1'b0);
      chk("n_xfer4", 128'(nx[0]), 128'(11));
      chk("n_done4", 128'(ndone[0]), 128'(1));
      chk("edge_idx0", 128'(fv[0][0]), 128'(4));
      chk("edge_idx1", 128'(fv[0][1]), 128'(8));
      chk("edge_idx10", 128'(fv[0][10]), 128'(44));
      chk("edge_done", 128'(done_edge[0]), 128'(44));
      chk("vec128_idx1", got[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("vec128_idx10", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Same key under random backpressure
      run(3'b001, 1'b1, 1'b0);
      chk("bp_n_xfer", 128'(nx[0]), 128'(11));
      chk("bp_n_done", 128'(ndone[0]), 128'(1));
      chk("bp_idx10", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Starts while busy and during the final transfer are ignored
      run(3'b001, 1'b0, 1'b1);
      chk("poke_n_xfer", 128'(nx[0]), 128'(11));
      chk("poke_edge10", 128'(fv[0][10]), 128'(44));
      chk("poke_done", 128'(done_edge[0]), 128'(44));
      repeat (6) @(negedge clk);
      chk("poke_no_relaunch", 128'(busy[0]), 128'(0));
      chk("poke_no_valid", 128'(vld[0]), 128'(0));

      // Reset in the middle of an expansion, then a fresh key
      mon_en = 1'b0;
      rdy = 3'b111;
      @(posedge clk); #1 start = 3'b001;
      @(posedge clk); #1 start = '0;
      repeat (19) @(posedge clk);
      #1 chk("mid_busy", 128'(busy[0]), 128'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 128'(busy[0]), 128'(0));
      chk("mid_rst_valid", 128'(vld[0]), 128'(0));
      chk("mid_rst_rk_out", rko[0], '0);
      chk("mid_rst_rk_idx", 128'(idx[0]), 128'(0));
      repeat (2) @(negedge clk);
      chk("mid_rst_hold", 128'({busy[0], vld[0], done[0]}), 128'(0));
      rst = 1'b0;
      key4 = 128'h000102030405060708090a0b0c0d0e0f;
      model(0, 4, {key4, 128'h0});
      run(3'b001, 1'b0, 1'b0);
      chk("rst_n_xfer", 128'(nx[0]), 128'(11));
      chk("rst_idx10", got[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("rst_edge10", 128'(fv[0][10]), 128'(44));

      // AES-192 and AES-256 vectors with random backpressure
      key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
      key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      model(1, 6, {key6, 64'h0});
      model(2, 8, key8);
      run(3'b110, 1'b1, 1'b0);
      chk("vec192_idx12", got[1][12], 128'he98ba06f448c773c8ecc720401002202);
      chk("vec256_idx14", got[2][14], 128'hfe4890d1e6188d0b046df344706c631e);
      chk("n_xfer6", 128'(nx[1]), 128'(13));
      chk("n_xfer8", 128'(nx[2]), 128'(15));
      chk("n_done68", 128'({ndone[1][3:0], ndone[2][3:0]}), 128'(8'h11));

      // Random keys on all three widths
      for (int r = 0; r < 3; r++) begin
         key4 = {$urandom, $urandom, $urandom, $urandom};
         key6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         key8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         model(0, 4, {key4, 128'h0});
         model(1, 6, {key6, 64'h0});
         model(2, 8, key8);
         run(3'b111, 1'b1, 1'b0);
         chk("rnd_xfer4", 128'(nx[0]), 128'(11));
         chk("rnd_xfer6", 128'(nx[1]), 128'(13));
         chk("rnd_xfer8", 128'(nx[2]), 128'(15));
         chk("rnd_done", 128'(ndone[0] + ndone[1] + ndone[2]), 128'(3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
